// File: rtl/cmp_rr_sched_if.sv
// Bundle of request/operand and response signals between client blocks and
// the shared comparator scheduler; master = clients, slave = scheduler.
interface cmp_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  eq;
  logic                  gt;
  logic                  sm;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, rsp_valid, rsp_id, eq, gt, sm
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, rsp_valid, rsp_id, eq, gt, sm
  );
endinterface

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one registered magnitude comparator among NREQ
// requesters. Define CMP_SIGNED_EN for a two's-complement compare.
module cmp_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_rr_sched_if.slave     sif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic             eq_q;
  logic             gt_q;
  logic             sm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [IDW-1:0]   winner_d;
  logic             found_d;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW:0]     idx_d;
  logic             cmp_eq;
  logic             cmp_lt;

  logic [WIDTH-1:0] a_slice [NREQ];
  logic [WIDTH-1:0] b_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_slice[gi] = sif.a_in[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = sif.b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    winner_d = '0;
    found_d  = 1'b0;
    idx_d    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx_d = {1'b0, rr_ptr_q} + (IDW+1)'(off);
      if (idx_d >= (IDW+1)'(NREQ)) begin
        idx_d = idx_d - (IDW+1)'(NREQ);
      end
      if (sif.req[idx_d[IDW-1:0]]) begin
        winner_d = idx_d[IDW-1:0];
        found_d  = 1'b1;
      end
    end
  end

  assign rr_ptr_d = (winner_d == IDW'(NREQ - 1)) ? '0 : winner_d + IDW'(1);

`ifdef CMP_SIGNED_EN
  assign cmp_lt = $signed(a_q) < $signed(b_q);
`else
  assign cmp_lt = a_q < b_q;
`endif
  assign cmp_eq = (a_q == b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      rsp_id_q    <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      sm_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            a_q      <= a_slice[winner_d];
            b_q      <= b_slice[winner_d];
            gnt_q    <= NREQ'(1) << winner_d;
            rsp_id_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= ST_CMP;
          end
        end
        ST_CMP: begin
          eq_q        <= cmp_eq;
          gt_q        <= !cmp_eq && !cmp_lt;
          sm_q        <= cmp_lt;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.gnt       = gnt_q;
  assign sif.busy      = busy_q;
  assign sif.rsp_valid = rsp_valid_q;
  assign sif.rsp_id    = rsp_id_q;
  assign sif.eq        = eq_q;
  assign sif.gt        = gt_q;
  assign sif.sm        = sm_q;

endmodule

// File: tb/tb_cmp_rr_sched.sv
// Directed bench for cmp_rr_sched: grant order, latency, results, reset abort
// and signedness, all against hand-computed expectations.
module tb_cmp_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cmp_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) sif ();

  cmp_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
    sif.a_in[id*WIDTH +: WIDTH] = a;
    sif.b_in[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"},  32'(sif.gnt), 0);
    chk({tag, ".busy"}, 32'(sif.busy), 0);
    chk({tag, ".rspv"}, 32'(sif.rsp_valid), 0);
    chk({tag, ".id"},   32'(sif.rsp_id), 0);
    chk({tag, ".flag"}, 32'({sif.eq, sif.gt, sif.sm}), 0);
  endtask

  // Called at #1 after an edge with the DUT idle and req[id] already high.
  // flags = {eq, gt, sm}.
  task automatic expect_txn(input string tag, input int id, input logic [2:0] flags,
                            input bit drop);
    int waits;
    waits = 0;
    do begin
      tick();
      waits++;
    end while (sif.gnt == '0 && waits < 8);
    chk({tag, ".lat"},  32'(waits), 1);
    chk({tag, ".gnt"},  32'(sif.gnt), 32'(1) << id);
    chk({tag, ".busy"}, 32'(sif.busy), 1);
    tick();
    chk({tag, ".rspv"}, 32'(sif.rsp_valid), 1);
    chk({tag, ".gnt0"}, 32'(sif.gnt), 0);
    chk({tag, ".id"},   32'(sif.rsp_id), 32'(id));
    chk({tag, ".flag"}, 32'({sif.eq, sif.gt, sif.sm}), 32'(flags));
    if (drop) sif.req[id] = 1'b0;
    tick();
    chk({tag, ".rspv0"}, 32'(sif.rsp_valid), 0);
    chk({tag, ".idle"},  32'(sif.busy), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sgn_flags;
    n_tests = 0;
    n_fail  = 0;
    rst_n    = 1'b0;
    sif.req  = '0;
    sif.a_in = '0;
    sif.b_in = '0;

    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request 0, 5 vs 3; operands scrambled and a busy-time req ignored.
    set_op(0, 4'h5, 4'h3);
    sif.req = 4'b0001;
    tick();
    chk("t1.gnt", 32'(sif.gnt), 32'h1);
    set_op(0, 4'h0, 4'hF);
    sif.req[3] = 1'b1;
    tick();
    chk("t1.rspv", 32'(sif.rsp_valid), 1);
    chk("t1.id",   32'(sif.rsp_id), 0);
    chk("t1.flag", 32'({sif.eq, sif.gt, sif.sm}), 32'b010);
    sif.req = 4'b0000;
    tick();
    chk("t1.rspv0", 32'(sif.rsp_valid), 0);
    tick();
    chk("t1.nognt", 32'(sif.gnt), 0);
    chk("t1.hold",  32'({sif.eq, sif.gt, sif.sm}), 32'b010);

    set_op(2, 4'hF, 4'hF);
    sif.req = 4'b0100;
    expect_txn("eq", 2, 3'b100, 1'b1);
    set_op(2, 4'h2, 4'h6);
    sif.req = 4'b0100;
    expect_txn("sm", 2, 3'b001, 1'b1);

    // Abort during CMP: everything clears immediately and no response follows.
    set_op(1, 4'h6, 4'h1);
    sif.req = 4'b0010;
    tick();
    chk("abort.gnt", 32'(sif.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    sif.req = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort.norsp", 32'(sif.rsp_valid), 0);
    end

    // All four held: grant order from rr_ptr=0.
    set_op(0, 4'h1, 4'h6);
    set_op(1, 4'h7, 4'h7);
    set_op(2, 4'h6, 4'h3);
    set_op(3, 4'h0, 4'h5);
    sif.req = 4'b1111;
    expect_txn("all0", 0, 3'b001, 1'b1);
    expect_txn("all1", 1, 3'b100, 1'b1);
    expect_txn("all2", 2, 3'b010, 1'b1);
    expect_txn("all3", 3, 3'b001, 1'b1);

    // Wrap and fairness with 0 and 3 both held.
    sif.req = 4'b1001;
    expect_txn("wrap0", 0, 3'b001, 1'b0);
    expect_txn("fair3", 3, 3'b001, 1'b0);
    expect_txn("fair0", 0, 3'b001, 1'b1);
    expect_txn("fair3b", 3, 3'b001, 1'b1);

`ifdef CMP_SIGNED_EN
    sgn_flags = 3'b001;
`else
    sgn_flags = 3'b010;
`endif
    set_op(1, 4'h8, 4'h7);
    sif.req = 4'b0010;
    expect_txn("sign", 1, sgn_flags, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
